// File: rtl/pipe_snapshot_ctrl.sv
// Debug run-control and snapshot streamer for the pipelined MIPS core.
// Optional trailer: define PIPE_SNAP_CHECKSUM_EN to append an XOR checksum byte to each frame.
module pipe_snapshot_ctrl #(
    parameter int LEN        = 32,
    parameter int NUM_STAGES = 4,
    parameter int LATCH_W    = 128
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    input  logic [1:0]                    cmd_code,
    output logic                          cmd_ready,
    input  logic                          halt_flag,
    input  logic [LEN-1:0]                in_pc,
    input  logic [NUM_STAGES*LATCH_W-1:0] in_latches,
    output logic                          cpu_enable,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          halted,
    output logic                          busy,
    output logic [LEN-1:0]                cycle_count
);

    localparam int SHADOW_W = 2*LEN + NUM_STAGES*LATCH_W;
    localparam int N_DATA   = SHADOW_W / 8;
`ifdef PIPE_SNAP_CHECKSUM_EN
    localparam int N_FRAME  = N_DATA + 1;
`else
    localparam int N_FRAME  = N_DATA;
`endif
    localparam int IDX_W    = $clog2(N_FRAME + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FRAME - 1);
`ifdef PIPE_SNAP_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(N_DATA - 1);
`endif

    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_DUMP = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_CAPTURE,
        S_SEND,
        S_HALTED
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 halt_set;
    logic                 tx_accept;
    logic [SHADOW_W-1:0]  shadow;
    logic [IDX_W-1:0]     byte_idx;
`ifdef PIPE_SNAP_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    assign tx_accept = tx_valid && tx_ready;

    always_comb begin
        state_nxt = state;
        halt_set  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_code)
                        CMD_RUN:  state_nxt = S_RUN;
                        CMD_STEP: state_nxt = S_STEP;
                        CMD_DUMP: state_nxt = S_CAPTURE;
                        default:  state_nxt = S_IDLE;
                    endcase
                end
            end
            // Only DUMP leaves HALTED; RUN/STEP are accepted but have no effect.
            S_HALTED: begin
                if (cmd_valid && cmd_code == CMD_DUMP)
                    state_nxt = S_CAPTURE;
            end
            S_RUN: begin
                if (halt_flag) begin
                    state_nxt = S_CAPTURE;
                    halt_set  = 1'b1;
                end
            end
            S_STEP: begin
                state_nxt = S_CAPTURE;
                halt_set  = halt_flag;
            end
            S_CAPTURE: state_nxt = S_SEND;
            S_SEND: begin
                if (tx_accept && byte_idx == LAST_IDX)
                    state_nxt = halted ? S_HALTED : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cpu_enable  <= 1'b0;
            busy        <= 1'b0;
            cmd_ready   <= 1'b1;
            halted      <= 1'b0;
            cycle_count <= '0;
        end else begin
            state      <= state_nxt;
            cpu_enable <= (state_nxt == S_RUN) || (state_nxt == S_STEP);
            busy       <= (state_nxt == S_RUN) || (state_nxt == S_STEP) ||
                          (state_nxt == S_CAPTURE) || (state_nxt == S_SEND);
            cmd_ready  <= (state_nxt == S_IDLE) || (state_nxt == S_HALTED);
            if (halt_set)
                halted <= 1'b1;
            if (cpu_enable)
                cycle_count <= cycle_count + LEN'(1);
        end
    end

    // Shadow is a shift register: the byte on the wire is always the one below shadow[15:8].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow   <= '0;
            byte_idx <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
`ifdef PIPE_SNAP_CHECKSUM_EN
            csum     <= '0;
`endif
        end else if (state == S_CAPTURE) begin
            shadow   <= {in_latches, cycle_count, in_pc};
            byte_idx <= '0;
            tx_valid <= 1'b1;
            tx_data  <= in_pc[7:0];
`ifdef PIPE_SNAP_CHECKSUM_EN
            csum     <= '0;
`endif
        end else if (state == S_SEND && tx_accept) begin
            if (byte_idx == LAST_IDX) begin
                tx_valid <= 1'b0;
            end else begin
                byte_idx <= byte_idx + IDX_W'(1);
                shadow   <= shadow >> 8;
`ifdef PIPE_SNAP_CHECKSUM_EN
                csum     <= csum ^ tx_data;
                if (byte_idx == LAST_DATA_IDX)
                    tx_data <= csum ^ tx_data;
                else
                    tx_data <= shadow[15:8];
`else
                tx_data  <= shadow[15:8];
`endif
            end
        end
    end

endmodule

// File: tb/tb_pipe_snapshot_ctrl.sv
// Directed bench for pipe_snapshot_ctrl: step, run/halt, stalled dump, dropped command, mid-frame reset.
// Follows PIPE_SNAP_CHECKSUM_EN for the expected frame length and trailer.
module tb_pipe_snapshot_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_code = 2'b00;
    logic         cmd_ready;
    logic         halt_flag = 1'b0;
    logic [31:0]  in_pc = '0;
    logic [511:0] in_latches = '0;
    logic         cpu_enable;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b1;
    logic         halted;
    logic         busy;
    logic [31:0]  cycle_count;

    pipe_snapshot_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_ready  (cmd_ready),
        .halt_flag  (halt_flag),
        .in_pc      (in_pc),
        .in_latches (in_latches),
        .cpu_enable (cpu_enable),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .halted     (halted),
        .busy       (busy),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] frame     [0:79];
    logic [7:0] exp_frame [0:79];
    int         flen;
    int         exp_len;
    int         stall_bad;
    bit         cpu_seen;
    logic [511:0] lat_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic send_cmd(input logic [1:0] code);
        cmd_valid = 1'b1;
        cmd_code  = code;
        tick();
        cmd_valid = 1'b0;
        cmd_code  = 2'b00;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cpu_enable"}, cpu_enable, 0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cycle_count"}, cycle_count, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    // mode 0: sink always ready; mode 1: ready on alternate cycles.
    // stop_after > 0 returns once that many bytes are accepted; inject_at >= 0 sends RUN mid-frame.
    task automatic recv(input string tag, input int mode, input int stop_after, input int inject_at);
        int         cyc = 0;
        logic [7:0] hold = '0;
        bit         stalled = 0;
        bit         started = 0;
        bit         injected = 0;
        bit         done = 0;
        flen = 0;
        stall_bad = 0;
        cpu_seen = 0;
        for (int i = 0; i < 80; i++) frame[i] = 8'hxx;
        while (cyc < 400 && !done) begin
            tx_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (stalled && tx_data !== hold) stall_bad++;
            stalled = 0;
            cmd_valid = 1'b0;
            if (inject_at >= 0 && !injected && tx_valid && flen == inject_at) begin
                chk({tag, "_cmd_ready_in_send"}, cmd_ready, 0);
                cmd_valid = 1'b1;
                cmd_code  = 2'b01;
                injected  = 1;
            end
            if (cpu_enable) cpu_seen = 1;
            if (tx_valid) begin
                started = 1;
                if (tx_ready) begin
                    if (flen < 80) frame[flen] = tx_data;
                    flen++;
                end else begin
                    hold    = tx_data;
                    stalled = 1;
                end
            end else if (started) begin
                done = 1;
            end
            if (!done) begin
                tick();
                cyc++;
                if (stop_after > 0 && flen == stop_after) done = 1;
            end
        end
        cmd_valid = 1'b0;
        cmd_code  = 2'b00;
        tx_ready  = 1'b1;
        chk({tag, "_timeout"}, done, 1);
    endtask

    task automatic build_exp(input logic [31:0] pc, input logic [31:0] cc, input logic [511:0] lat);
        logic [7:0] x = '0;
        for (int i = 0; i < 4; i++) begin
            exp_frame[i]     = pc[8*i +: 8];
            exp_frame[4 + i] = cc[8*i +: 8];
        end
        for (int k = 0; k < 64; k++) exp_frame[8 + k] = lat[8*k +: 8];
        exp_len = 72;
`ifdef PIPE_SNAP_CHECKSUM_EN
        for (int i = 0; i < 72; i++) x = x ^ exp_frame[i];
        exp_frame[72] = x;
        exp_len = 73;
`endif
    endtask

    task automatic compare_frame(input string tag);
        int bad = 0;
        chk({tag, "_len"}, flen, exp_len);
        for (int i = 0; i < exp_len; i++)
            if (frame[i] !== exp_frame[i]) bad++;
        chk({tag, "_bad_bytes"}, bad, 0);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) lat_a[8*k +: 8] = 8'(8'h80 + k);
        lat_a[63:0] = 64'h0123456789ABCDEF;

        // Reset state
        do_reset();
        check_reset_vals("rst");

        // STEP: one enabled cycle, then a 72-byte frame back to IDLE
        in_pc = 32'h0000_0040;
        send_cmd(2'b10);
        chk("step_cpu_en_on", cpu_enable, 1);
        chk("step_busy", busy, 1);
        tick();
        chk("step_cpu_en_off", cpu_enable, 0);
        chk("step_cycle_count", cycle_count, 1);
        recv("step", 0, 0, -1);
        chk("step_head8", {frame[7], frame[6], frame[5], frame[4],
                           frame[3], frame[2], frame[1], frame[0]}, 64'h00000001_00000040);
        build_exp(32'h40, 32'h1, 512'h0);
        compare_frame("step_frame");
        chk("step_cpu_seen", cpu_seen, 0);
        chk("step_halted", halted, 0);
        chk("step_idle_ready", cmd_ready, 1);
        chk("step_idle_busy", busy, 0);

        // RUN with halt after 10 enabled cycles
        do_reset();
        in_pc = 32'h0000_1000;
        send_cmd(2'b01);
        chk("run_cpu_en", cpu_enable, 1);
        repeat (9) tick();
        halt_flag = 1'b1;
        tick();
        halt_flag = 1'b0;
        chk("run_cpu_en_drop", cpu_enable, 0);
        chk("run_halted", halted, 1);
        chk("run_cycle_count", cycle_count, 10);
        recv("run", 0, 0, -1);
        chk("run_cc_bytes", {frame[7], frame[6], frame[5], frame[4]}, 32'h0000000A);
        build_exp(32'h1000, 32'd10, 512'h0);
        compare_frame("run_frame");
        chk("run_halted_after", halted, 1);
        chk("run_halted_ready", cmd_ready, 1);
        send_cmd(2'b01);
        chk("halted_run_ignored", cpu_enable, 0);
        tick();
        chk("halted_run_ignored2", cpu_enable, 0);
        chk("halted_busy", busy, 0);
        chk("halted_cc_frozen", cycle_count, 10);

        // DUMP from HALTED with a stalling sink; inputs change after capture
        in_pc = 32'h1122_3344;
        in_latches = lat_a;
        send_cmd(2'b11);
        tick();
        in_latches = ~lat_a;
        in_pc = 32'h0;
        recv("dump", 1, 0, -1);
        chk("dump_stage0", {frame[15], frame[14], frame[13], frame[12],
                            frame[11], frame[10], frame[9], frame[8]}, 64'h0123456789ABCDEF);
        build_exp(32'h1122_3344, 32'd10, lat_a);
        compare_frame("dump_frame");
        chk("dump_stall_stable", stall_bad, 0);
        chk("dump_back_halted", halted, 1);
        chk("dump_back_ready", cmd_ready, 1);

        // RUN dropped while sending
        do_reset();
        in_pc = 32'hCAFE_0001;
        in_latches = lat_a;
        send_cmd(2'b11);
        recv("drop", 0, 0, 5);
        build_exp(32'hCAFE_0001, 32'd0, lat_a);
        compare_frame("drop_frame");
        chk("drop_cpu_seen", cpu_seen, 0);
        chk("drop_cpu_en", cpu_enable, 0);
        chk("drop_busy", busy, 0);
        chk("drop_ready", cmd_ready, 1);
        chk("drop_halted", halted, 0);
        chk("drop_cc", cycle_count, 0);

        // Reset after 30 bytes, then a complete frame
        do_reset();
        in_pc = 32'h0BAD_F00D;
        send_cmd(2'b11);
        recv("abort", 0, 30, -1);
        chk("abort_count", flen, 30);
        chk("abort_valid_before", tx_valid, 1);
        reset = 1'b1;
        #1;
        check_reset_vals("abort");
        tick();
        reset = 1'b0;
        tick();
        send_cmd(2'b11);
        recv("after_abort", 0, 0, -1);
        build_exp(32'h0BAD_F00D, 32'd0, lat_a);
        compare_frame("after_abort_frame");

        // All-zero snapshot except PC = 0xA5
        do_reset();
        in_pc = 32'h0000_00A5;
        in_latches = '0;
        send_cmd(2'b11);
        recv("zero", 0, 0, -1);
`ifdef PIPE_SNAP_CHECKSUM_EN
        chk("csum_len", flen, 73);
        chk("csum_trailer", frame[72], 8'hA5);
`else
        chk("zero_len", flen, 72);
        chk("zero_last", frame[71], 8'h00);
`endif
        build_exp(32'hA5, 32'd0, 512'h0);
        compare_frame("zero_frame");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_snapshot_ctrl.md
Name: pipe_snapshot_ctrl

Overview:
Debug run-control and snapshot engine for the pipelined MIPS core. It gates core execution in RUN and STEP modes, and counts executed cycles. On halt, step completion or an explicit dump command, it freezes the PC, the cycle count and NUM_STAGES inter-stage latch buses into a shadow buffer. It then streams the snapshot byte-wise over a valid/ready link to the UART/debug host.

Parameters:
LEN, 32, PC and cycle-counter width; multiple of 8
NUM_STAGES, 4, number of inter-stage latch buses captured
LATCH_W, 128, width of each latch bus; multiple of 8

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command strobe
cmd_code  in  2  00 NOP, 01 RUN, 10 STEP, 11 DUMP
cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready
halt_flag  in  1  halt reached write-back (from core)
in_pc  in  LEN  current core PC
in_latches  in  NUM_STAGES*LATCH_W  flat latch buses; stage 0 in LSBs
cpu_enable  out  1  core clock-enable / stall-release
tx_data  out  8  snapshot byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts byte
halted  out  1  sticky halt indicator
busy  out  1  high in RUN, STEP, CAPTURE, SEND
cycle_count  out  LEN  cycles with cpu_enable=1

Behaviour:
- Reset values (async): state IDLE; cpu_enable 0, tx_valid 0, tx_data 0, halted 0, busy 0, cycle_count 0, byte index 0, shadow buffer 0.
- All outputs registered.
- cmd_ready = 1 only in IDLE and HALTED. Commands arriving in other states are dropped, not queued. NOP is accepted with no effect.
- IDLE: RUN -> RUN; STEP -> STEP; DUMP -> CAPTURE.
- HALTED: RUN and STEP are ignored (accepted, no transition). DUMP -> CAPTURE. Exit only by reset.
- RUN: cpu_enable=1 from the cycle after acceptance. When halt_flag is sampled 1:
  - cpu_enable drops the next cycle.
  - halted is set.
  - next state CAPTURE.
- STEP: cpu_enable=1 for exactly one cycle, then CAPTURE. If halt_flag=1 during that cycle, halted is set.
- cycle_count increments by 1 on every cycle cpu_enable=1 and wraps modulo 2^LEN.
- CAPTURE: one cycle. Latches in_pc, cycle_count (value including the last enabled cycle) and in_latches into the shadow buffer, clears the byte index, then goes to SEND.
- SEND:
  - tx_valid=1 and byte index advances on tx_valid & tx_ready.
  - tx_data holds stable while tx_valid & !tx_ready.
  - Byte order: PC LSB-first (LEN/8 bytes), cycle_count LSB-first (LEN/8), then stage 0..NUM_STAGES-1, each LSB-first (LATCH_W/8 bytes).
  - Total N = 2*LEN/8 + NUM_STAGES*LATCH_W/8; 72 at defaults.
  - After the last byte is accepted, tx_valid drops next cycle and state -> HALTED if halted, else IDLE.
- The shadow buffer is immune to core activity during SEND (the core is stalled; changes in in_latches are ignored).
- halt_flag is ignored outside RUN and STEP.
- Reset mid-SEND: tx_valid drops asynchronously and the partial frame is abandoned.

Optional Feature:
PIPE_SNAP_CHECKSUM_EN
- Defined: one trailer byte is appended after the N data bytes, equal to the XOR of all N data bytes. The frame is N+1 bytes, and the trailer obeys the same handshake.
- Undefined: no trailer; the frame is exactly N bytes and there is no XOR logic.

Test Plan:
- Reset, then STEP with in_pc=0x00000040 -> cpu_enable high exactly 1 cycle, cycle_count=1. Frame starts 40 00 00 00 01 00 00 00; 72 bytes total; back to IDLE with halted=0.
- RUN, then halt_flag=1 after 10 enabled cycles -> cpu_enable low next cycle, cycle_count=10, halted=1. Frame bytes 4..7 = 0A 00 00 00; final state HALTED; subsequent RUN leaves cpu_enable 0.
- DUMP with tx_ready toggling 1/0 every cycle, latch stage 0 = 0x...0123456789ABCDEF -> bytes 8..15 = EF CD AB 89 67 45 23 01; no byte duplicated or skipped; tx_data stable while stalled.
- RUN issued during SEND -> cmd_ready=0, command dropped, frame completes unchanged, state IDLE afterwards.
- Assert reset after byte 30 of a DUMP -> tx_valid=0 immediately, all outputs at reset values. A new DUMP yields a complete 72-byte frame.
- With PIPE_SNAP_CHECKSUM_EN, DUMP after reset with all inputs 0 except in_pc=0xA5 -> 73 bytes, last byte = A5.
